// File: rtl/quantum_scheduler.sv
// Time-slice preemption controller: counts user-mode ticks against a programmable quantum and
// raises a level interrupt on expiry. Optional saturating expiry counter under QUANTUM_STATS_EN.
module quantum_scheduler #(
  parameter int QUANTUM_WIDTH   = 16,
  parameter int DEFAULT_QUANTUM = 1024,
  parameter int STAT_WIDTH      = 8
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     is_Bios,
  input  logic                     is_kernel,
  input  logic                     enable,
  input  logic                     cfg_we,
  input  logic                     cfg_arm,
  input  logic [QUANTUM_WIDTH-1:0] cfg_quantum,
  input  logic                     irq_ack,
  output logic                     interruption,
  output logic                     armed,
  output logic [QUANTUM_WIDTH-1:0] remaining,
`ifdef QUANTUM_STATS_EN
  output logic [STAT_WIDTH-1:0]    preempt_count,
`endif
  output logic [1:0]               state_dbg
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    PEND = 2'd2,
    PRIV = 2'd3
  } state_t;

  state_t                   state_q, state_d;
  logic [QUANTUM_WIDTH-1:0] quantum_q, quantum_d;
  logic [QUANTUM_WIDTH-1:0] remaining_q, remaining_d;
  logic                     irq_q, irq_d;
  logic                     armed_q, armed_d;
  logic                     priv;

  assign priv = is_Bios | is_kernel;

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q     <= IDLE;
      quantum_q   <= QUANTUM_WIDTH'(DEFAULT_QUANTUM);
      remaining_q <= '0;
      irq_q       <= 1'b0;
      armed_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      quantum_q   <= quantum_d;
      remaining_q <= remaining_d;
      irq_q       <= irq_d;
      armed_q     <= armed_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    quantum_d   = quantum_q;
    remaining_d = remaining_q;
    irq_d       = irq_q;
    armed_d     = armed_q;
    if (cfg_we) begin
      quantum_d = cfg_quantum;
      if (!cfg_arm || cfg_quantum == '0) begin
        // A disarm (or a zero quantum) wins over everything, including a pending irq.
        state_d     = IDLE;
        armed_d     = 1'b0;
        irq_d       = 1'b0;
        remaining_d = '0;
      end else begin
        armed_d = 1'b1;
        case (state_q)
          IDLE: begin
            state_d     = PRIV;
            remaining_d = cfg_quantum;
          end
          RUN, PRIV: remaining_d = cfg_quantum;
          default: ;
        endcase
      end
    end else begin
      case (state_q)
        PRIV: begin
          remaining_d = quantum_q;
          if (!priv) state_d = RUN;
        end
        RUN: begin
          if (priv) begin
            state_d     = PRIV;
            remaining_d = quantum_q;
          end else if (enable) begin
            if (remaining_q <= QUANTUM_WIDTH'(1)) begin
              state_d     = PEND;
              irq_d       = 1'b1;
              remaining_d = '0;
            end else begin
              remaining_d = remaining_q - QUANTUM_WIDTH'(1);
            end
          end
        end
        PEND: begin
          if (irq_ack) begin
            state_d     = PRIV;
            irq_d       = 1'b0;
            remaining_d = quantum_q;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef QUANTUM_STATS_EN
  logic [STAT_WIDTH-1:0] count_q;

  // Only the RUN branch can reach PEND, so this is exactly the expiry event.
  always_ff @(posedge clock) begin
    if (!reset) begin
      count_q <= '0;
    end else if (state_q == RUN && state_d == PEND && count_q != '1) begin
      count_q <= count_q + STAT_WIDTH'(1);
    end
  end

  assign preempt_count = count_q;
`endif

  assign interruption = irq_q;
  assign armed        = armed_q;
  assign remaining    = remaining_q;
  assign state_dbg    = state_q;

endmodule

// File: tb/tb_quantum_scheduler.sv
// Randomised + directed bench for quantum_scheduler with a behavioural reference model and
// an expected-value queue checked by an independent monitor one tick after each clock edge.
module tb_quantum_scheduler;

  localparam int QW = 16;
  localparam int DQ = 1024;
  localparam int SW = 2;
  localparam int W  = 1 + 1 + QW + 2 + SW;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          is_Bios = 1'b0;
  logic          is_kernel = 1'b0;
  logic          enable = 1'b0;
  logic          cfg_we = 1'b0;
  logic          cfg_arm = 1'b0;
  logic [QW-1:0] cfg_quantum = '0;
  logic          irq_ack = 1'b0;
  logic          interruption;
  logic          armed;
  logic [QW-1:0] remaining;
  logic [1:0]    state_dbg;
`ifdef QUANTUM_STATS_EN
  logic [SW-1:0] preempt_count;
`endif

  quantum_scheduler #(
    .QUANTUM_WIDTH(QW),
    .DEFAULT_QUANTUM(DQ),
    .STAT_WIDTH(SW)
  ) dut (
    .clock(clock),
    .reset(reset),
    .is_Bios(is_Bios),
    .is_kernel(is_kernel),
    .enable(enable),
    .cfg_we(cfg_we),
    .cfg_arm(cfg_arm),
    .cfg_quantum(cfg_quantum),
    .irq_ack(irq_ack),
    .interruption(interruption),
    .armed(armed),
    .remaining(remaining),
`ifdef QUANTUM_STATS_EN
    .preempt_count(preempt_count),
`endif
    .state_dbg(state_dbg)
  );

  // ---------------- clock ----------------
  always #5 clock = ~clock;

  // ---------------- reference model ----------------
  // Mode flags rather than a state register: disarmed, waiting for ack, or counting user ticks.
  int m_armed, m_pending, m_counting, m_rem, m_q, m_cnt;
  int checks = 0;
  int errors = 0;
  int cycle  = 0;
  logic [W-1:0] exp_q[$];

  function automatic void model_step(input bit rst, input bit priv, input bit en, input bit we,
                                     input bit arm, input int q, input bit ack);
    if (rst) begin
      m_armed = 0; m_pending = 0; m_counting = 0; m_rem = 0; m_q = DQ; m_cnt = 0;
    end else if (we) begin
      m_q = q;
      if (!arm || q == 0) begin
        m_armed = 0; m_pending = 0; m_counting = 0; m_rem = 0;
      end else if (!m_armed) begin
        m_armed = 1; m_counting = 0; m_rem = q;
      end else if (!m_pending) begin
        m_rem = q;
      end
    end else if (!m_armed) begin
      // disarmed: nothing moves
    end else if (m_pending) begin
      if (ack) begin
        m_pending = 0; m_counting = 0; m_rem = m_q;
      end
    end else if (!m_counting) begin
      m_rem = m_q;
      if (!priv) m_counting = 1;
    end else if (priv) begin
      m_counting = 0; m_rem = m_q;
    end else if (en) begin
      m_rem = m_rem - 1;
      if (m_rem == 0) begin
        m_pending = 1; m_counting = 0;
        if (m_cnt < (1 << SW) - 1) m_cnt++;
      end
    end
  endfunction

  function automatic logic [W-1:0] model_expect();
    logic [1:0] st;
    if (!m_armed) st = 2'd0;
    else if (m_pending) st = 2'd2;
    else if (m_counting) st = 2'd1;
    else st = 2'd3;
    return {m_pending[0], m_armed[0], m_rem[QW-1:0], st, m_cnt[SW-1:0]};
  endfunction

  // ---------------- driver ----------------
  task automatic drive(input bit rst, input bit bios, input bit kern, input bit en,
                       input bit we, input bit arm, input int q, input bit ack);
    @(negedge clock);
    reset = ~rst; is_Bios = bios; is_kernel = kern; enable = en;
    cfg_we = we; cfg_arm = arm; cfg_quantum = q[QW-1:0]; irq_ack = ack;
    model_step(rst, bios | kern, en, we, arm, q, ack);
    exp_q.push_back(model_expect());
  endtask

  task automatic idle_cycles(input int n, input bit en, input bit kern);
    for (int i = 0; i < n; i++) drive(0, 0, kern, en, 0, 0, 0, 0);
  endtask

  // ---------------- monitor / scoreboard ----------------
  task automatic check_field(input string name, input int act, input int exp_v);
    checks++;
    if (act != exp_v) begin
      errors++;
      $display("FAIL %s cycle %0d: got %0d expected %0d", name, cycle, act, exp_v);
    end
  endtask

  always @(posedge clock) begin
    logic [W-1:0] e;
    #1;
    cycle++;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check_field("interruption", int'(interruption), int'(e[W-1]));
      check_field("armed", int'(armed), int'(e[W-2]));
      check_field("remaining", int'(remaining), int'(e[W-3 -: QW]));
      check_field("state", int'(state_dbg), int'(e[SW+1 -: 2]));
`ifdef QUANTUM_STATS_EN
      check_field("preempt_count", int'(preempt_count), int'(e[SW-1:0]));
`endif
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    // reset, then idle enables must not move anything
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 1, 0, 0, 0, 0);
    idle_cycles(3, 1, 0);
    idle_cycles(1, 0, 0);

    // q=3: 3,3,2,1 -> irq with remaining 0, held without ack
    drive(0, 0, 0, 1, 1, 1, 3, 0);
    idle_cycles(4, 1, 0);
    for (int i = 0; i < 10; i++) drive(0, i[0], i[1], 1, 0, 0, 0, 0);
    drive(0, 0, 0, 1, 0, 0, 0, 1);
    idle_cycles(1, 0, 0);

    // q=5 reload mid-RUN, kernel entry restarts slice, resumes after
    drive(0, 0, 0, 0, 1, 1, 5, 0);
    idle_cycles(2, 1, 0);
    idle_cycles(4, 1, 1);
    drive(0, 1, 0, 1, 0, 0, 0, 0);
    idle_cycles(3, 1, 0);

    // run to PEND, then disarm; zero quantum arm stays idle
    idle_cycles(4, 1, 0);
    drive(0, 0, 0, 1, 0, 0, 0, 1);
    idle_cycles(7, 1, 0);
    drive(0, 0, 0, 1, 1, 0, 9, 0);
    drive(0, 0, 0, 1, 1, 1, 0, 0);
    idle_cycles(3, 1, 0);

    // q=1, five expire/ack rounds (saturates a 2-bit counter)
    drive(0, 0, 0, 0, 1, 1, 1, 0);
    for (int r = 0; r < 5; r++) begin
      idle_cycles(2, 1, 0);
      drive(0, 0, 0, 1, 0, 0, 0, 1);
    end
    idle_cycles(2, 1, 0);

    // mid-PEND reset drops the irq
    drive(0, 0, 0, 1, 1, 1, 2, 0);
    idle_cycles(3, 1, 0);
    drive(1, 0, 0, 1, 0, 0, 0, 1);

    // randomised traffic
    for (int i = 0; i < 3000; i++) begin
      bit rst, bios, kern, en, we, arm, ack;
      int q;
      rst  = ($urandom_range(0, 199) == 0);
      bios = ($urandom_range(0, 7) == 0);
      kern = ($urandom_range(0, 5) == 0);
      en   = ($urandom_range(0, 3) != 0);
      we   = ($urandom_range(0, 19) == 0);
      arm  = ($urandom_range(0, 5) != 0);
      q    = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 65535))
                                          : int'($urandom_range(0, 7));
      ack  = ($urandom_range(0, 3) == 0);
      drive(rst, bios, kern, en, we, arm, q, ack);
    end

    // drain the last expectation, bounded
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clock);
    @(negedge clock);
    if (exp_q.size() > 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expectations, expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
